// File: rtl/gnr_pkg.sv
// Shared constants and types for golden_nonce_reporter: record layout and serializer state.
package gnr_pkg;

    localparam int REC_BYTES = 5;
    localparam int NONCE_W   = 32;
    localparam int DEF_TAG_W = 4;
    localparam int REC_W     = DEF_TAG_W + NONCE_W;

    typedef enum logic {
        IDLE,
        SEND
    } gnr_state_e;

    function automatic int rec_width(input int tag_w);
        return tag_w + NONCE_W;
    endfunction

endpackage

// File: rtl/golden_nonce_reporter_if.sv
// Byte stream toward the host transmitter: valid/ready handshake, tx_last marks the final record byte.
interface golden_nonce_reporter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/gnr_sync_fifo.sv
// Synchronous FIFO with flush and level output; combinational head read, writes ignored when full.
// Flush takes priority over a same-cycle write or pop.
module gnr_sync_fifo #(
    parameter int W    = 36,
    parameter int DL2  = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           wr_en,
    input  logic [W-1:0]   wr_dat,
    input  logic           rd_en,
    output logic [W-1:0]   rd_dat,
    output logic [DL2:0]   level,
    output logic           full,
    output logic           empty
);
    localparam int DEPTH = 1 << DL2;

    logic [W-1:0]   mem [DEPTH];
    logic [DL2-1:0] wr_ptr;
    logic [DL2-1:0] rd_ptr;
    logic           do_wr;
    logic           do_rd;

    assign full   = (level == (DL2+1)'(DEPTH));
    assign empty  = (level == '0);
    assign do_wr  = wr_en && !full;
    assign do_rd  = rd_en && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

// File: rtl/golden_nonce_reporter.sv
// Queues golden nonces tagged with the job number and streams each as 5 bytes (tag, nonce MSB first).
// First byte one cycle after capture; 6 cycles/record; tx_data held while tx_ready=0. GNR_DUP_FILTER_EN drops repeats.
module golden_nonce_reporter
    import gnr_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int TAG_W      = 4
) (
    input  logic                    hash_clk,
    input  logic                    reset,
    input  logic                    golden_nonce_valid,
    input  logic [31:0]             golden_nonce,
    input  logic                    new_work,
    golden_nonce_reporter_if.master tx,
    output logic [TAG_W-1:0]        job_tag,
    output logic [DEPTH_LOG2:0]     fifo_level,
    output logic [7:0]              overflow_cnt
);
    localparam int RW = rec_width(TAG_W);

    gnr_state_e               state;
    logic [8*REC_BYTES-1:0]   sreg;
    logic [2:0]               idx;
    logic [RW-1:0]            rd_dat;
    logic                     full;
    logic                     empty;
    logic                     wr_en;
    logic                     pop;
    logic                     dup;
    logic                     fresh;

`ifdef GNR_DUP_FILTER_EN
    logic        last_vld;
    logic [31:0] last_nonce;

    // Tag only changes on new_work, which also invalidates, so a nonce match implies same tag.
    assign dup = last_vld && (last_nonce == golden_nonce);

    always_ff @(posedge hash_clk) begin
        if (!reset) begin
            last_vld   <= 1'b0;
            last_nonce <= '0;
        end else if (new_work) begin
            last_vld   <= 1'b0;
        end else if (wr_en) begin
            last_vld   <= 1'b1;
            last_nonce <= golden_nonce;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign fresh = golden_nonce_valid && !new_work && !dup;
    assign wr_en = fresh && !full;
    // A flush in the same cycle wins, so nothing is loaded from a queue being discarded.
    assign pop   = (state == IDLE) && !empty && !new_work;

    gnr_sync_fifo #(.W(RW), .DL2(DEPTH_LOG2)) u_fifo (
        .clk    (hash_clk),
        .reset  (reset),
        .flush  (new_work),
        .wr_en  (wr_en),
        .wr_dat ({job_tag, golden_nonce}),
        .rd_en  (pop),
        .rd_dat (rd_dat),
        .level  (fifo_level),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge hash_clk) begin
        if (!reset) begin
            job_tag      <= '0;
            overflow_cnt <= '0;
        end else begin
            if (new_work) job_tag <= job_tag + 1'b1;
            if (fresh && full && overflow_cnt != 8'hff) overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

    assign tx.tx_data = sreg[8*REC_BYTES-1 -: 8];

    always_ff @(posedge hash_clk) begin
        if (!reset) begin
            state       <= IDLE;
            sreg        <= '0;
            idx         <= '0;
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        sreg        <= {8'(rd_dat[RW-1:32]), rd_dat[31:0]};
                        idx         <= '0;
                        tx.tx_valid <= 1'b1;
                        tx.tx_last  <= 1'b0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (tx.tx_ready) begin
                        sreg <= sreg << 8;
                        if (idx == 3'(REC_BYTES-1)) begin
                            tx.tx_valid <= 1'b0;
                            tx.tx_last  <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            idx         <= idx + 1'b1;
                            tx.tx_last  <= (idx == 3'(REC_BYTES-2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Directed scenarios plus random traffic, each cycle compared against a queue-based reference model.
module tb_golden_nonce_reporter;
    localparam int DL2   = 2;
    localparam int TW    = 4;
    localparam int DEPTH = 1 << DL2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              gv;
    logic [31:0]       nonce;
    logic              nw;
    logic [TW-1:0]     job_tag;
    logic [DL2:0]      fifo_level;
    logic [7:0]        ovf;

    golden_nonce_reporter_if tx_if ();

    golden_nonce_reporter #(.DEPTH_LOG2(DL2), .TAG_W(TW)) dut (
        .hash_clk           (clk),
        .reset              (rst_n),
        .golden_nonce_valid (gv),
        .golden_nonce       (nonce),
        .new_work           (nw),
        .tx                 (tx_if),
        .job_tag            (job_tag),
        .fifo_level         (fifo_level),
        .overflow_cnt       (ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [35:0] m_q[$];
    logic [7:0]  m_out[$];
    int          m_tag, m_ovf;
    bit          m_lv;
    logic [31:0] m_ln;
    logic [7:0]  dut_log[$];
    logic [7:0]  exp1 [5] = '{8'h01, 8'h0e, 8'h33, 8'h33, 8'h7a};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit v, input logic [31:0] n, input bit w, input bit rdy);
        logic [35:0] rec;
        bit busy, full, dup;
        if (!r) begin
            m_q.delete(); m_out.delete();
            m_tag = 0; m_ovf = 0; m_lv = 0;
            return;
        end
        busy = m_out.size() > 0;
        full = m_q.size() == DEPTH;
        if (busy && rdy) begin
            void'(m_out.pop_front());
        end else if (!busy && m_q.size() > 0 && !w) begin
            rec = m_q.pop_front();
            m_out.push_back({4'h0, rec[35:32]});
            for (int k = 3; k >= 0; k--) m_out.push_back(rec[8*k +: 8]);
        end
        if (w) begin
            m_q.delete();
            m_tag = (m_tag + 1) % (1 << TW);
            m_lv = 0;
        end else if (v) begin
            dup = 0;
`ifdef GNR_DUP_FILTER_EN
            dup = m_lv && (m_ln == n);
`endif
            if (!dup) begin
                if (full) begin
                    if (m_ovf < 255) m_ovf++;
                end else begin
                    m_q.push_back({4'(m_tag), n});
                    m_lv = 1; m_ln = n;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("tx_valid", tx_if.tx_valid, m_out.size() > 0);
        check_eq("tx_last", tx_if.tx_last, m_out.size() == 1);
        if (m_out.size() > 0) check_eq("tx_data", tx_if.tx_data, m_out[0]);
        check_eq("fifo_level", fifo_level, m_q.size());
        check_eq("job_tag", job_tag, m_tag);
        check_eq("overflow_cnt", ovf, m_ovf);
    endtask

    task automatic step(input bit r, input bit v, input logic [31:0] n, input bit w, input bit rdy);
        rst_n = r; gv = v; nonce = n; nw = w; tx_if.tx_ready = rdy;
        if (r && tx_if.tx_valid && rdy) dut_log.push_back(tx_if.tx_data);
        @(posedge clk);
        model_update(r, v, n, w, rdy);
        #1;
        compare_all();
    endtask

    task automatic idle(input int cycles, input bit rdy);
        for (int i = 0; i < cycles; i++) step(1, 0, 32'h0, 0, rdy);
    endtask

    initial begin
        // Reset state
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_eq("rst_valid", tx_if.tx_valid, 0);
        check_eq("rst_data", tx_if.tx_data, 0);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_tag", job_tag, 0);
        check_eq("rst_ovf", ovf, 0);

        // Single result and first-byte latency
        step(1, 0, 0, 1, 1);
        step(1, 1, 32'h0e33337a, 0, 1);
        check_eq("lat_capture_edge", tx_if.tx_valid, 0);
        idle(1, 1);
        check_eq("lat_next_edge", tx_if.tx_valid, 1);
        idle(8, 1);
        check_eq("single_len", dut_log.size(), 5);
        for (int i = 0; i < 5 && i < dut_log.size(); i++) check_eq("single_byte", dut_log[i], exp1[i]);
        check_eq("single_level", fifo_level, 0);

        // Backpressure and overflow
        dut_log.delete();
        for (int i = 1; i <= 4; i++) step(1, 1, 32'(i), 0, 0);
        check_eq("bp_level", fifo_level, 3);
        check_eq("bp_hold_tag", tx_if.tx_data, 8'h01);
        for (int i = 5; i <= 6; i++) step(1, 1, 32'(i), 0, 0);
        check_eq("bp_level_full", fifo_level, 4);
        check_eq("bp_ovf", ovf, 1);
        idle(40, 1);
        check_eq("bp_drain_len", dut_log.size(), 25);
        for (int r = 0; r < 5 && dut_log.size() == 25; r++) begin
            check_eq("bp_tag", dut_log[5*r], 8'h01);
            check_eq("bp_nonce", {dut_log[5*r+1], dut_log[5*r+2], dut_log[5*r+3], dut_log[5*r+4]}, 32'(r + 1));
        end

        // Saturation
        for (int i = 0; i < 305; i++) step(1, 1, 32'h5000 + 32'(i), 0, 0);
        check_eq("sat_ovf", ovf, 255);
        for (int i = 0; i < 5; i++) step(1, 1, 32'h6000, 0, 0);
        check_eq("sat_hold", ovf, 255);

        // Flush mid-transfer
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        dut_log.delete();
        step(1, 1, 32'h1000000a, 0, 0);
        step(1, 1, 32'h1000000b, 0, 0);
        step(1, 1, 32'h1000000c, 0, 0);
        idle(2, 1);
        step(1, 1, 32'hdeadbeef, 1, 1);
        idle(20, 1);
        check_eq("flush_len", dut_log.size(), 5);
        if (dut_log.size() == 5) begin
            check_eq("flush_tag", dut_log[0], 8'h01);
            check_eq("flush_nonce", {dut_log[1], dut_log[2], dut_log[3], dut_log[4]}, 32'h1000000a);
        end
        check_eq("flush_job_tag", job_tag, 2);
        check_eq("flush_level", fifo_level, 0);

        // Reset mid-operation
        step(1, 1, 32'h20000001, 0, 0);
        step(1, 1, 32'h20000002, 0, 0);
        step(1, 1, 32'h20000003, 0, 0);
        step(1, 1, 32'h20000004, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check_eq("mrst_valid", tx_if.tx_valid, 0);
        check_eq("mrst_level", fifo_level, 0);
        check_eq("mrst_tag", job_tag, 0);
        check_eq("mrst_ovf", ovf, 0);

`ifdef GNR_DUP_FILTER_EN
        dut_log.delete();
        step(1, 0, 0, 1, 1);
        step(1, 1, 32'h0000abcd, 0, 1);
        idle(2, 1);
        step(1, 1, 32'h0000abcd, 0, 1);
        idle(12, 1);
        check_eq("dup_len", dut_log.size(), 5);
        step(1, 0, 0, 1, 1);
        step(1, 1, 32'h0000abcd, 0, 1);
        idle(12, 1);
        check_eq("dup_new_len", dut_log.size(), 10);
        if (dut_log.size() == 10) check_eq("dup_new_tag", dut_log[5], 8'h02);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 3) == 0) ? 32'h0000abcd : $urandom,
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
